// File: rtl/i2c_seq_pkg.sv
// Shared types and field layout for the I2C command sequencer.
package i2c_seq_pkg;

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, RESP} seq_state_e;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;
    localparam int CMD_W  = ADDR_W + 1 + DATA_W;
    localparam int RSP_W  = 1 + DATA_W;

    // Command word is {addr, rw, wdata}; response word is {err, rdata}.
    localparam int CMD_WDATA_LSB = 0;
    localparam int CMD_RW_BIT    = DATA_W;
    localparam int CMD_ADDR_LSB  = DATA_W + 1;
    localparam int RSP_RDATA_LSB = 0;
    localparam int RSP_ERR_BIT   = DATA_W;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              rw;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] rdata;
    } rsp_t;

endpackage

// File: rtl/i2c_cmd_sequencer_if.sv
// Host-side command/response handshake of the I2C command sequencer.
interface i2c_cmd_sequencer_if;
    logic                            cmd_valid;
    logic                            cmd_ready;
    logic [i2c_seq_pkg::ADDR_W-1:0]  cmd_addr;
    logic                            cmd_rw;
    logic [i2c_seq_pkg::DATA_W-1:0]  cmd_wdata;
    logic                            rsp_valid;
    logic                            rsp_ready;
    logic [i2c_seq_pkg::DATA_W-1:0]  rsp_rdata;
    logic                            rsp_err;

    modport master (
        output cmd_valid, cmd_addr, cmd_rw, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_rw, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/i2c_sync_fifo.sv
// First-word-fall-through synchronous FIFO; callers never push full or pop empty.
module i2c_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Queues host commands and issues them one at a time to the I2C master,
// returning one response (read byte or timeout) per command.
module i2c_cmd_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int CMD_DEPTH      = 4,
    parameter int RSP_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 13
) (
    input  logic                clk,
    input  logic                reset,
    i2c_cmd_sequencer_if.slave  host,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_data_in,
    output logic                m_rw,
    output logic                m_enable,
    input  logic [DATA_W-1:0]   m_data_out,
    input  logic                m_ready,
    output logic                busy
);
    localparam int CMD_CW = $clog2(CMD_DEPTH) + 1;
    localparam int RSP_CW = $clog2(RSP_DEPTH) + 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    seq_state_e        state;
    logic              err;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        rdy_pipe;
    logic              rdy_s;

    cmd_t              cmd_in;
    logic [CMD_W-1:0]  cmd_head;
    logic              cmd_push, cmd_pop, cmd_full, cmd_empty;
    logic [CMD_CW-1:0] cmd_count;

    rsp_t              rsp_in;
    logic [RSP_W-1:0]  rsp_head;
    logic              rsp_push, rsp_pop, rsp_full, rsp_empty;
    logic [RSP_CW-1:0] rsp_count;

    logic              issue;
    logic              timeout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rdy_pipe <= '0;
        else       rdy_pipe <= {rdy_pipe[0], m_ready};
    end
    assign rdy_s = rdy_pipe[1];

    assign cmd_in   = '{addr: host.cmd_addr, rw: host.cmd_rw, wdata: host.cmd_wdata};
    assign cmd_push = host.cmd_valid && !cmd_full;
    assign cmd_pop  = issue;

    i2c_sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cmd_push),
        .wdata (cmd_in),
        .pop   (cmd_pop),
        .rdata (cmd_head),
        .full  (cmd_full),
        .empty (cmd_empty),
        .count (cmd_count)
    );

    assign rsp_in   = '{err: err, rdata: (m_rw == RW_READ && !err) ? m_data_out : '0};
    assign rsp_push = (state == RESP) && !rsp_full;
    assign rsp_pop  = host.rsp_ready && !rsp_empty;

    i2c_sync_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rsp_push),
        .wdata (rsp_in),
        .pop   (rsp_pop),
        .rdata (rsp_head),
        .full  (rsp_full),
        .empty (rsp_empty),
        .count (rsp_count)
    );

    // A response slot is reserved before issue so RESP can always push.
    assign issue   = (state == IDLE) && !cmd_empty && rdy_s &&
                     (rsp_count < RSP_CW'(RSP_DEPTH));
    assign timeout = (cnt >= TO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            m_addr    <= '0;
            m_data_in <= '0;
            m_rw      <= RW_WRITE;
            m_enable  <= 1'b0;
            err       <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        m_addr    <= cmd_head[CMD_ADDR_LSB +: ADDR_W];
                        m_rw      <= cmd_head[CMD_RW_BIT];
                        m_data_in <= cmd_head[CMD_WDATA_LSB +: DATA_W];
                        m_enable  <= 1'b1;
                        cnt       <= '0;
                        state     <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (!rdy_s) begin
                        m_enable <= 1'b0;
                        cnt      <= '0;
                        state    <= WAIT_DONE;
                    end else if (timeout) begin
                        m_enable <= 1'b0;
                        err      <= 1'b1;
                        cnt      <= '0;
                        state    <= RESP;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (rdy_s) begin
                        err   <= 1'b0;
                        cnt   <= '0;
                        state <= RESP;
                    end else if (timeout) begin
                        err   <= 1'b1;
                        cnt   <= '0;
                        state <= RESP;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    err   <= 1'b0;
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO storage is unreset, so the head is masked while nothing is queued.
    assign host.cmd_ready = !cmd_full;
    assign host.rsp_valid = !rsp_empty;
    assign host.rsp_rdata = rsp_empty ? '0 : rsp_head[RSP_RDATA_LSB +: DATA_W];
    assign host.rsp_err   = rsp_empty ? 1'b0 : rsp_head[RSP_ERR_BIT];
    assign busy           = (state != IDLE) || (cmd_count != '0);
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for the I2C command sequencer with a behavioural master model.
module tb_i2c_cmd_sequencer;
    import i2c_seq_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    i2c_cmd_sequencer_if hif();
    logic [6:0] m_addr;
    logic [7:0] m_data_in;
    logic [7:0] m_data_out = 8'h00;
    logic       m_rw, m_enable, m_ready, busy;

    i2c_cmd_sequencer #(.CMD_DEPTH(4), .RSP_DEPTH(4), .TIMEOUT_CYCLES(4096), .CNT_W(13)) dut (
        .clk        (clk),
        .reset      (reset),
        .host       (hif),
        .m_addr     (m_addr),
        .m_data_in  (m_data_in),
        .m_rw       (m_rw),
        .m_enable   (m_enable),
        .m_data_out (m_data_out),
        .m_ready    (m_ready),
        .busy       (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc++;

    // Master model: drops ready after seeing enable, stays busy, then returns data.
    bit         manual   = 1'b0;
    bit         stuck    = 1'b0;
    bit         saw_full = 1'b0;
    logic       mdl_rdy  = 1'b1;
    int         mst      = 0;
    int         bcnt     = 0;
    int         busy_len = 5;
    int         rise_cyc = 0;
    logic [6:0] issued[$];

    assign m_ready = manual ? 1'b0 : mdl_rdy;

    always @(negedge clk) begin
        if (!manual) begin
            if (mst == 0) begin
                if (m_enable && !stuck) begin
                    mdl_rdy = 1'b0;
                    bcnt    = busy_len;
                    issued.push_back(m_addr);
                    mst     = 1;
                end
            end else if (bcnt == 0) begin
                mdl_rdy    = 1'b1;
                m_data_out = m_rw ? ({1'b0, m_addr} ^ 8'h42) : 8'hEE;
                rise_cyc   = cyc;
                mst        = 0;
            end else begin
                bcnt--;
            end
        end
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [6:0] a, input logic r, input logic [7:0] d);
        int n = 0;
        hif.cmd_valid = 1'b1;
        hif.cmd_addr  = a;
        hif.cmd_rw    = r;
        hif.cmd_wdata = d;
        while (!hif.cmd_ready && n < 2000) begin
            saw_full = 1'b1;
            @(negedge clk);
            n++;
        end
        check("push_wait", 16'(n == 2000), 16'd0);
        @(negedge clk);
        hif.cmd_valid = 1'b0;
    endtask

    task automatic pop_rsp(input logic [7:0] exp_d, input logic exp_e, input string tag);
        int n = 0;
        while (!hif.rsp_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 16'(hif.rsp_valid), 16'd1);
        check({tag, "_rdata"}, 16'(hif.rsp_rdata), 16'(exp_d));
        check({tag, "_err"},   16'(hif.rsp_err),   16'(exp_e));
        hif.rsp_ready = 1'b1;
        @(negedge clk);
        hif.rsp_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    logic [7:0] bp_exp [6] = '{8'h00, 8'h53, 8'h00, 8'h51, 8'h00, 8'h57};

    initial begin
        int n;
        int base;
        reset         = 1'b1;
        hif.cmd_valid = 1'b0;
        hif.cmd_addr  = '0;
        hif.cmd_rw    = 1'b0;
        hif.cmd_wdata = '0;
        hif.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 16'(hif.cmd_ready), 16'd1);
        check("rst_rsp_valid", 16'(hif.rsp_valid), 16'd0);
        check("rst_rsp_rdata", 16'(hif.rsp_rdata), 16'd0);
        check("rst_rsp_err",   16'(hif.rsp_err),   16'd0);
        check("rst_m_addr",    16'(m_addr),        16'd0);
        check("rst_m_data_in", 16'(m_data_in),     16'd0);
        check("rst_m_rw",      16'(m_rw),          16'd0);
        check("rst_m_enable",  16'(m_enable),      16'd0);
        check("rst_busy",      16'(busy),          16'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Write path and issue/response latency
        push(7'h50, 1'b0, 8'hA5);
        check("wr_en_lat1", 16'(m_enable), 16'd0);
        check("wr_busy",    16'(busy),     16'd1);
        @(negedge clk);
        check("wr_en_lat2", 16'(m_enable),  16'd1);
        check("wr_m_addr",  16'(m_addr),    16'h50);
        check("wr_m_data",  16'(m_data_in), 16'hA5);
        check("wr_m_rw",    16'(m_rw),      16'd0);
        n = 0;
        while (m_enable && n < 20) begin @(negedge clk); n++; end
        check("wr_en_drop",   16'(m_enable), 16'd0);
        check("wr_drop_rdy0", 16'(m_ready),  16'd0);
        n = 0;
        while (!hif.rsp_valid && n < 100) begin @(negedge clk); n++; end
        check("wr_rsp_lat", 16'(cyc - rise_cyc), 16'd4);
        pop_rsp(8'h00, 1'b0, "wr_rsp");

        // Read path
        push(7'h3C, 1'b1, 8'h00);
        pop_rsp(8'h7E, 1'b0, "rd_rsp");

        // Backpressure: response FIFO fills, FSM stalls, then drains in order
        base     = issued.size();
        saw_full = 1'b0;
        for (int k = 0; k < 6; k++) push(7'(16 + k), 1'(k), 8'(32 + k));
        check("bp_cmd_full_seen", 16'(saw_full), 16'd1);
        n = 0;
        while (issued.size() < base + 4 && n < 500) begin @(negedge clk); n++; end
        repeat (30) @(negedge clk);
        check("bp_issued",    16'(issued.size() - base),   16'd4);
        check("bp_state",     16'(dut.state),              16'(IDLE));
        check("bp_cmd_count", 16'(dut.u_cmd_fifo.count),   16'd2);
        check("bp_rsp_count", 16'(dut.u_rsp_fifo.count),   16'd4);
        for (int k = 0; k < 6; k++) pop_rsp(bp_exp[k], 1'b0, $sformatf("bp_rsp%0d", k));
        for (int k = 0; k < 6; k++)
            check($sformatf("bp_order%0d", k), 16'(issued[base + k]), 16'(16 + k));

        // Timeout: master never acknowledges, following command runs normally
        stuck = 1'b1;
        push(7'h22, 1'b1, 8'h00);
        push(7'h23, 1'b1, 8'h00);
        n = 0;
        while (!m_enable && n < 20) begin @(negedge clk); n++; end
        n = 0;
        while (m_enable && n < 5000) begin @(negedge clk); n++; end
        check("to_en_cycles", 16'(n), 16'd4096);
        stuck = 1'b0;
        pop_rsp(8'h00, 1'b1, "to_rsp");
        pop_rsp(8'h61, 1'b0, "to_next");

        // Reset in WAIT_DONE with two commands queued
        busy_len = 20;
        push(7'h30, 1'b0, 8'hC3);
        push(7'h31, 1'b0, 8'h01);
        push(7'h32, 1'b1, 8'h02);
        n = 0;
        while (m_enable && n < 50) begin @(negedge clk); n++; end
        check("rr_state",     16'(dut.state),            16'(WAIT_DONE));
        check("rr_cmd_count", 16'(dut.u_cmd_fifo.count), 16'd2);
        reset = 1'b1;
        #1;
        check("rr_m_enable",  16'(m_enable),      16'd0);
        check("rr_cmd_ready", 16'(hif.cmd_ready), 16'd1);
        check("rr_rsp_valid", 16'(hif.rsp_valid), 16'd0);
        check("rr_busy",      16'(busy),          16'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        base  = issued.size();
        repeat (60) @(negedge clk);
        check("rr_no_rsp",   16'(hif.rsp_valid),         16'd0);
        check("rr_no_issue", 16'(issued.size() - base), 16'd0);
        check("rr_idle",     16'(busy),                  16'd0);
        busy_len = 5;

        // Push on the same edge the FSM pops, with two entries queued
        manual = 1'b1;
        repeat (4) @(negedge clk);
        base = issued.size();
        push(7'h40, 1'b0, 8'h11);
        push(7'h41, 1'b1, 8'h00);
        repeat (2) @(negedge clk);
        check("sp_pre_count", 16'(dut.u_cmd_fifo.count), 16'd2);
        check("sp_pre_en",    16'(m_enable),             16'd0);
        manual = 1'b0;
        repeat (2) @(negedge clk);
        push(7'h45, 1'b1, 8'h00);
        check("sp_count",  16'(dut.u_cmd_fifo.count), 16'd2);
        check("sp_en",     16'(m_enable),             16'd1);
        check("sp_m_addr", 16'(m_addr),               16'h40);
        pop_rsp(8'h00, 1'b0, "sp_rsp0");
        pop_rsp(8'h03, 1'b0, "sp_rsp1");
        pop_rsp(8'h07, 1'b0, "sp_rsp2");
        check("sp_order0", 16'(issued[base]),     16'h40);
        check("sp_order1", 16'(issued[base + 1]), 16'h41);
        check("sp_order2", 16'(issued[base + 2]), 16'h45);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/i2c_cmd_sequencer.md
Name: i2c_cmd_sequencer

Overview:
- Host-side command front end that sits directly upstream of the I2C master top-level.
- Buffers host transactions (address, rw, write byte) in a command FIFO and issues them one at a time over the master's addr/data_in/rw/enable/ready interface.
- Returns one response per command (read byte or timeout error) through a response FIFO.
- Runs on the system clock; the master's ready is treated as asynchronous and synchronised internally.

Parameters:
CMD_DEPTH, 4, command FIFO entries (power of 2, ≥2)
RSP_DEPTH, 4, response FIFO entries (power of 2, ≥2)
TIMEOUT_CYCLES, 4096, clk cycles allowed in each wait state before error abort
CNT_W, 13, timeout counter width (must hold TIMEOUT_CYCLES)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  host command valid
cmd_ready  output  1  command FIFO not full
cmd_addr  input  7  7-bit slave address
cmd_rw  input  1  1=read, 0=write
cmd_wdata  input  8  write byte (ignored for reads)
rsp_valid  output  1  response FIFO not empty
rsp_ready  input  1  host accepts response
rsp_rdata  output  8  read byte; 0 for writes and errors
rsp_err  output  1  1 = command timed out
m_addr  output  7  to master addr
m_data_in  output  8  to master data_in
m_rw  output  1  to master rw
m_enable  output  1  to master enable
m_data_out  input  8  from master data_out
m_ready  input  1  from master ready (async)
busy  output  1  state != IDLE or command FIFO not empty

Behaviour:
- Reset (async, active-high): all FIFOs flushed; cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, m_addr=0, m_data_in=0, m_rw=0, m_enable=0, busy=0; state=IDLE; sync flops=0.
- Reset asserted mid-transaction aborts immediately: m_enable drops asynchronously, no response is produced, and queued commands are lost.
- m_ready passes through a 2-flop synchroniser giving rdy_s, which has 2 cycles of latency. Only rdy_s is used.
- FIFOs are first-word-fall-through with synchronous push/pop:
  - Push on valid&ready.
  - Simultaneous push and pop on a non-full, non-empty FIFO keeps the count unchanged.
  - Pop on empty and push on full are impossible by construction.
- Command FIFO write data is {addr, rw, wdata}, 16 bits. Response FIFO data is {err, rdata}, 9 bits.
- FSM states:
  - IDLE:
    - If the command FIFO is not empty, the response FIFO has a free slot, and rdy_s=1: register the head into m_addr/m_rw/m_data_in, pop, set m_enable=1, go to WAIT_BUSY.
    - Otherwise hold. m_enable=0.
  - WAIT_BUSY:
    - Hold m_enable=1 until rdy_s=0 (master accepted), then m_enable=0 and go to WAIT_DONE.
    - If the timeout counter reaches TIMEOUT_CYCLES-1: m_enable=0, err=1, go to RESP.
  - WAIT_DONE:
    - On rdy_s=1, go to RESP with err=0.
    - On timeout, go to RESP with err=1.
  - RESP:
    - Push {err, rw&!err ? m_data_out : 8'h00} into the response FIFO, clear err, go to IDLE. Takes 1 cycle.
    - m_data_out is sampled here. It is quasi-static because the master has been ready ≥2 cycles.
- The timeout counter clears on every state transition and increments each cycle in WAIT_BUSY/WAIT_DONE. It saturates and never wraps.
- Reserving a response slot before issue guarantees the RESP push never finds the FIFO full.
- m_addr/m_rw/m_data_in are held stable from issue until the next issue.
- Command latency: cmd push to m_enable rise is 2 cycles when idle (FIFO write, then IDLE decision) with rdy_s=1.
- Response latency: rdy_s rise to rsp_valid is 2 cycles (RESP, FIFO write).
- busy is combinational from state and FIFO empty.

Decomposition:
- Package i2c_seq_pkg holds:
  - the state enum (IDLE, WAIT_BUSY, WAIT_DONE, RESP);
  - the command-word and response-word field widths and offsets;
  - the RW_READ/RW_WRITE constants.
- One sub-module, i2c_sync_fifo, parameterised by WIDTH/DEPTH, with full, empty and count outputs. It is instantiated twice: command and response.
- The synchroniser is inline (two flops).

Test Plan:
- Write path: push addr=7'h50, rw=0, wdata=8'hA5 with model master ready=1.
  - Expect m_enable rise 2 cycles later with m_addr=50, m_data_in=A5, m_rw=0.
  - Expect m_enable to drop after the master deasserts ready.
  - After ready returns, expect one response rsp_rdata=00, rsp_err=0.
- Read path: push addr=7'h3C, rw=1; model returns m_data_out=8'h7E.
  - Expect a response with rdata=7E, err=0.
- Backpressure: hold rsp_ready=0 and push 6 commands.
  - Expect cmd_ready=0 after the FIFO fills.
  - Expect exactly RSP_DEPTH=4 transactions issued, then the FSM stalls in IDLE.
  - Releasing rsp_ready drains all 6 in order.
- Timeout: the model never drops ready after enable.
  - Expect m_enable low after 4096 cycles and a response err=1, rdata=00.
  - The next queued command then issues normally.
- Reset mid-transaction: assert reset while in WAIT_DONE with 2 commands queued.
  - Expect m_enable=0, cmd_ready=1, rsp_valid=0, busy=0 immediately.
  - After release, no stale response appears.
- Simultaneous push/pop: push a command on the same cycle the FSM pops the head, with the FIFO holding 2.
  - Expect the count to remain 2 and order preserved.
